inst_queue: RTL and testbench

- Parametrised multi-entry instruction register for the fetch stage. It succeeds the single-entry current instruction register.
- Buffers fetched instruction words between instruction memory and decode, using a valid/ready handshake on both sides.
- Generates the PC-advance enable from its occupancy, so fetch stalls when the queue is full.
- Supports a flush for branch redirect.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/inst_queue_if.sv | 35 +++
 rtl/iq_ptr_ctrl.sv | 88 ++++++++
 rtl/inst_queue.sv | 83 ++++++++
 tb/tb_inst_queue.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Fetch-stage shared definitions.
// Provides the default instruction width, the instruction word type and the
// default instruction-queue depth used by the fetch-stage blocks.
package fetch_pkg;

    localparam int unsigned INST_W   = 67;
    localparam int unsigned IQ_DEPTH = 4;

    typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/inst_queue_if.sv
// Instruction-queue handshake bundle.
// Fetch side:  in_valid, in_inst  -> queue;  in_ready  <- queue
// Decode side: out_valid, out_inst <- queue; out_ready -> queue
// slave  : the queue's view of the bundle
// master : the surrounding fetch/decode (or bench) view of the bundle
interface inst_queue_if #(
    parameter int unsigned INST_W = fetch_pkg::INST_W
);

    logic              in_valid;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;

    modport slave (
        input  in_valid,
        input  in_inst,
        output in_ready,
        output out_valid,
        output out_inst,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_inst,
        input  in_ready,
        input  out_valid,
        input  out_inst,
        output out_ready
    );

endinterface

// File: rtl/iq_ptr_ctrl.sv
// Instruction-queue pointer/occupancy controller.
// Holds read/write pointers and the occupancy count, derives full/empty and
// decides push/pop for the storage in the parent.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_flush         discard all entries on the next edge
//   i_in_valid      fetch side presents a word
//   i_out_ready     decode side consumes the head
//   o_wr_ptr        write pointer (registered)
//   o_rd_ptr        read pointer (registered)
//   o_count         occupancy (registered)
//   o_full_c        count == DEPTH
//   o_empty_c       count == 0
//   o_push_c        word is written into storage this cycle
//   o_byp_c         word is forwarded straight to decode (IQ_BYPASS_EN only)
// Build option: IQ_BYPASS_EN enables the empty-queue zero-latency bypass.
module iq_ptr_ctrl #(
    parameter  int unsigned DEPTH = fetch_pkg::IQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    input  logic             i_out_ready,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic             o_push_c,
    output logic             o_byp_c
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_byp;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == CNT_W'(0));

`ifdef IQ_BYPASS_EN
    // Forward only into an empty queue; reset and flush both kill it.
    assign w_byp = w_empty && i_in_valid && !i_flush && !rst;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed word that decode takes immediately is never stored.
    assign w_push = i_in_valid && !w_full && !(w_byp && i_out_ready);
    assign w_pop  = !w_empty && i_out_ready;

    // Pointers wrap through natural PTR_W overflow (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_count   = r_count;
    assign o_full_c  = w_full;
    assign o_empty_c = w_empty;
    assign o_push_c  = w_push;
    assign o_byp_c   = w_byp;

endmodule

// File: rtl/inst_queue.sv
// Multi-entry fetch-stage instruction queue.
// Buffers fetched words between instruction memory and decode with
// valid/ready on both sides, and drives the PC-advance enable from occupancy.
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   flush      discard all entries (branch redirect)
//   bus        inst_queue_if.slave: in_valid/in_inst/in_ready (fetch side),
//              out_valid/out_inst/out_ready (decode side)
//   pc_enable  PC may advance (queue not full and no flush)
//   count      current occupancy
// Build option: IQ_BYPASS_EN adds a zero-latency path from in_* to out_*
// when the queue is empty; without it the fetch-to-decode latency is 1.
// DEPTH must be a power of two and at least 2.
module inst_queue #(
    parameter  int unsigned INST_W = fetch_pkg::INST_W,
    parameter  int unsigned DEPTH  = fetch_pkg::IQ_DEPTH,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    inst_queue_if.slave      bus,
    output logic             pc_enable,
    output logic [CNT_W-1:0] count
);

    import fetch_pkg::*;

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_byp;
    logic              w_in_ready;
    logic [INST_W-1:0] w_out_inst;

    iq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_in_valid  (bus.in_valid),
        .i_out_ready (bus.out_ready),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (w_count),
        .o_full_c    (w_full),
        .o_empty_c   (w_empty),
        .o_push_c    (w_push),
        .o_byp_c     (w_byp)
    );

    // Storage is deliberately not reset; only valid entries are ever visible.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[w_wr_ptr] <= bus.in_inst;
        end
    end

    // Head mux: stored head first, bypassed word only into an empty queue.
    always_comb begin
        w_out_inst = '0;
        if (!w_empty) begin
            w_out_inst = r_mem[w_rd_ptr];
        end else if (w_byp) begin
            w_out_inst = bus.in_inst;
        end
    end

    assign w_in_ready    = !w_full;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = !w_empty || w_byp;
    assign bus.out_inst  = w_out_inst;
    assign pc_enable     = w_in_ready && !flush;
    assign count         = w_count;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH=4, INST_W=67), with a
// queue-based reference model of the occupancy/ordering rules.
module tb_inst_queue;

    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             pc_enable;
    logic [CNT_W-1:0] count;

    int n_tests;
    int n_fail;

    inst_t mq[$];

    inst_queue_if #(.INST_W(INST_W)) bus ();

    inst_queue #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .pc_enable (pc_enable),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected combinational outputs from the queue contents.
    function automatic bit m_byp();
        return BYP && (mq.size() == 0) && (bus.in_valid === 1'b1) && !flush && !rst;
    endfunction

    function automatic logic m_in_ready();
        return mq.size() != DEPTH;
    endfunction

    function automatic logic m_out_valid();
        return (mq.size() != 0) || m_byp();
    endfunction

    function automatic inst_t m_out_inst();
        if (mq.size() != 0) return mq[0];
        if (m_byp()) return bus.in_inst;
        return '0;
    endfunction

    // Reference model: state update at the coming clock edge.
    function automatic void model_step();
        bit byp;
        bit acc;
        bit pop;
        byp = m_byp();
        if (rst || flush) begin
            mq.delete();
            return;
        end
        acc = bus.in_valid && (mq.size() < DEPTH);
        pop = (mq.size() != 0) && bus.out_ready;
        if (pop) void'(mq.pop_front());
        if (acc && !(byp && bus.out_ready)) mq.push_back(bus.in_inst);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst = INST_W'({$urandom(), $urandom(), $urandom()});
        bus.out_ready = 1'b0;
        tick();
        tick();
        #1;
        n_tests++; if (count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_tests++; if (pc_enable !== 1'b1) begin n_fail++; $display("FAIL reset_pc_enable: got %b expected 1", pc_enable); end
        n_tests++; if (bus.out_inst !== INST_W'(0)) begin n_fail++; $display("FAIL reset_out_inst: got %0h expected 0", bus.out_inst); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst = INST_W'(i);
            #1;
            n_tests++; if (count !== CNT_W'(i - 1)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", count, i - 1); end
            n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 1", bus.in_ready); end
            tick();
        end
        bus.in_inst = INST_W'(5);
        #1;
        n_tests++; if (count !== CNT_W'(4)) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", bus.in_ready); end
        n_tests++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL full_pc_enable: got %b expected 0", pc_enable); end
        n_tests++; if (bus.out_inst !== INST_W'(1)) begin n_fail++; $display("FAIL full_head: got %0h expected 1", bus.out_inst); end
        tick();
        #1;
        n_tests++; if (count !== CNT_W'(4)) begin n_fail++; $display("FAIL full_hold_count: got %0d expected 4", count); end
    endtask

    task automatic test_full_simul();
        bus.in_valid = 1'b1;
        bus.in_inst = INST_W'(5);
        bus.out_ready = 1'b1;
        #1;
        n_tests++; if (bus.out_inst !== INST_W'(1)) begin n_fail++; $display("FAIL simul_pop_word: got %0h expected 1", bus.out_inst); end
        tick();
        bus.out_ready = 1'b0;
        #1;
        n_tests++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL simul_count: got %0d expected 3", count); end
        n_tests++; if (bus.out_inst !== INST_W'(2)) begin n_fail++; $display("FAIL simul_head: got %0h expected 2", bus.out_inst); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (count !== CNT_W'(4)) begin n_fail++; $display("FAIL simul_accept: got %0d expected 4", count); end
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            n_tests++; if (bus.out_inst !== INST_W'(k)) begin n_fail++; $display("FAIL drain_order: got %0h expected %0h", bus.out_inst, k); end
            tick();
            #1;
        end
        n_tests++; if (count !== CNT_W'(0)) begin n_fail++; $display("FAIL drain_empty: got %0d expected 0", count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_order_wrap();
        int idx_in;
        int idx_out;
        int cyc;
        idx_in = 0;
        idx_out = 0;
        cyc = 0;
        while (idx_out < 10 && cyc < 200) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = (idx_in < 10);
            bus.in_inst = INST_W'(32'h10 + 32'(idx_in));
            #1;
            n_tests++; if (count > CNT_W'(4) || count !== CNT_W'(mq.size())) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", count, mq.size()); end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                n_tests++; if (bus.out_inst !== INST_W'(32'h10 + 32'(idx_out))) begin n_fail++; $display("FAIL wrap_order: got %0h expected %0h", bus.out_inst, 32'h10 + 32'(idx_out)); end
                idx_out++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) idx_in++;
            tick();
            cyc++;
        end
        n_tests++; if (idx_out != 10) begin n_fail++; $display("FAIL wrap_timeout: got %0d words expected 10", idx_out); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while (mq.size() != 0 && cyc < 220) begin tick(); cyc++; end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst = INST_W'(32'h30 + 32'(i));
            tick();
        end
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_inst = INST_W'(32'h99);
        bus.out_ready = 1'b1;
        #1;
        n_tests++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        n_tests++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL flush_pc_enable: got %b expected 0", pc_enable); end
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_tests++; if (count !== CNT_W'(0)) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
        n_tests++; if (pc_enable !== 1'b1) begin n_fail++; $display("FAIL flush_pc_after: got %b expected 1", pc_enable); end
    endtask

    task automatic test_bypass();
        bus.in_valid = 1'b1;
        bus.in_inst = INST_W'(32'hAB);
        bus.out_ready = 1'b1;
        #1;
`ifdef IQ_BYPASS_EN
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %b expected 1", bus.out_valid); end
        n_tests++; if (bus.out_inst !== INST_W'(32'hAB)) begin n_fail++; $display("FAIL byp_inst: got %0h expected ab", bus.out_inst); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (count !== CNT_W'(0)) begin n_fail++; $display("FAIL byp_count: got %0d expected 0", count); end
`else
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_valid: got %b expected 0", bus.out_valid); end
        n_tests++; if (bus.out_inst !== INST_W'(0)) begin n_fail++; $display("FAIL nobyp_inst: got %0h expected 0", bus.out_inst); end
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_tests++; if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL nobyp_count: got %0d expected 1", count); end
        n_tests++; if (bus.out_inst !== INST_W'(32'hAB)) begin n_fail++; $display("FAIL nobyp_late: got %0h expected ab", bus.out_inst); end
        bus.out_ready = 1'b1;
        tick();
`endif
        // Bypass with decode stalled must store the word normally.
        bus.in_valid = 1'b1;
        bus.in_inst = INST_W'(32'hCD);
        bus.out_ready = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== BYP) begin n_fail++; $display("FAIL stall_valid: got %b expected %b", bus.out_valid, BYP); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (count !== CNT_W'(1) || bus.out_inst !== INST_W'(32'hCD)) begin n_fail++; $display("FAIL stall_store: got %0d/%0h expected 1/cd", count, bus.out_inst); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            if (!hold) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_inst = INST_W'({$urandom(), $urandom(), $urandom()});
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            n_tests++; if (count !== CNT_W'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, count, mq.size()); end
            n_tests++; if (bus.in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, bus.in_ready, m_in_ready()); end
            n_tests++; if (bus.out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rnd_out_valid c=%0d: got %b expected %b", c, bus.out_valid, m_out_valid()); end
            n_tests++; if (bus.out_inst !== m_out_inst()) begin n_fail++; $display("FAIL rnd_out_inst c=%0d: got %0h expected %0h", c, bus.out_inst, m_out_inst()); end
            n_tests++; if (pc_enable !== (m_in_ready() && !flush)) begin n_fail++; $display("FAIL rnd_pc_enable c=%0d: got %b expected %b", c, pc_enable, m_in_ready() && !flush); end
            hold = bus.in_valid && !m_in_ready() && !flush && !rst;
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fill();
        test_full_simul();
        test_order_wrap();
        test_flush();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
